// File: rtl/cube_cfg_pkg.sv
// Shared types and constants for the cube configuration path.
// Contents:
//   CONF_MODE, CONF_BRIGHT  - command-class values carried in the upper nibble of a config byte
//   RST_CFG_BYTE            - config byte value at reset (brightness F)
//   sched_state_t           - write scheduler FSM states
//   src_t                   - requester identity (UART or button)
package cube_cfg_pkg;

    localparam logic [3:0] CONF_MODE    = 4'd0;
    localparam logic [3:0] CONF_BRIGHT  = 4'd1;
    localparam logic [7:0] RST_CFG_BYTE = 8'h1F;

    typedef enum logic {
        IDLE,
        WAIT_FRAME
    } sched_state_t;

    typedef enum logic {
        SRC_UART,
        SRC_BTN
    } src_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter. When both requests are active, the grant goes to the
// requester that was not granted last. The pointer advances only when a grant is
// actually issued (en high with at least one request).
// Ports:
//   clk  - clock
//   rst  - synchronous active-high reset
//   en   - grants are issued only while en is high
//   req  - request vector, bit 0 and bit 1
//   gnt  - one-hot (or zero) grant vector, combinational
module rr_arb2 #(
    parameter bit RST_LAST = 1'b1  // requester treated as granted last after reset
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    logic last_q;
    logic last_d;

    always_comb begin
        gnt = 2'b00;
        if (en) begin
            unique case (req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11:   gnt = last_q ? 2'b01 : 2'b10;
                default: gnt = 2'b00;
            endcase
        end
    end

    always_comb begin
        last_d = last_q;
        if (gnt != 2'b00) begin
            last_d = gnt[1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_q <= RST_LAST;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/config_write_scheduler.sv
// Shares the config-byte write path between the UART receiver and the button encoder.
// Non-mode commands go straight out; mode commands (upper nibble 0) are held until the
// scan engine's frame boundary, or force-issued after TIMEOUT cycles, so a mode switch
// never tears a displayed frame.
// Ports:
//   clk, rst                     - clock, synchronous active-high reset
//   uart_valid/uart_byte/uart_ready - UART requester handshake
//   btn_valid/btn_byte/btn_ready - button requester handshake
//   frame_boundary               - end-of-frame pulse from the scan engine
//   cfg_byte                     - command byte to the config block (holds last issued)
//   stall_mode_change            - low only in the cycle a mode command is presented
//   mode_pending                 - a mode command is waiting for a frame boundary
//   grant_src                    - source of the last accepted byte (0 UART, 1 button)
//   timeout_pulse                - one-cycle pulse when a mode command is force-issued
module config_write_scheduler
    import cube_cfg_pkg::*;
#(
    parameter int unsigned TIMEOUT  = 4096,
    parameter logic [7:0]  RST_BYTE = RST_CFG_BYTE
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       uart_valid,
    input  logic [7:0] uart_byte,
    output logic       uart_ready,
    input  logic       btn_valid,
    input  logic [7:0] btn_byte,
    output logic       btn_ready,
    input  logic       frame_boundary,
    output logic [7:0] cfg_byte,
    output logic       stall_mode_change,
    output logic       mode_pending,
    output logic       grant_src,
    output logic       timeout_pulse
);

    localparam int unsigned CW = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
    // With the timeout disabled the counter just saturates at all-ones.
    localparam logic [CW-1:0] CNT_MAX = (TIMEOUT == 0) ? {CW{1'b1}} : CW'(TIMEOUT - 1);

    sched_state_t  state_q;
    logic [7:0]    pend_q;
    logic [CW-1:0] cnt_q;

    logic [1:0] gnt;
    logic       accept;
    logic [7:0] acc_byte;
    src_t       acc_src;
    logic       timeout_hit;

    rr_arb2 #(
        .RST_LAST (1'b1)
    ) u_arb (
        .clk (clk),
        .rst (rst),
        .en  (state_q == IDLE),
        .req ({btn_valid, uart_valid}),
        .gnt (gnt)
    );

    assign uart_ready = gnt[0];
    assign btn_ready  = gnt[1];

    always_comb begin
        accept   = uart_ready | btn_ready;
        acc_byte = uart_ready ? uart_byte : btn_byte;
        acc_src  = uart_ready ? SRC_UART : SRC_BTN;
    end

    assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_MAX);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q           <= IDLE;
            pend_q            <= 8'h00;
            cnt_q             <= '0;
            cfg_byte          <= RST_BYTE;
            stall_mode_change <= 1'b1;
            mode_pending      <= 1'b0;
            grant_src         <= 1'b1;
            timeout_pulse     <= 1'b0;
        end else begin
            // Stall and timeout pulse are single-cycle strobes.
            stall_mode_change <= 1'b1;
            timeout_pulse     <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        grant_src <= acc_src;
                        if (acc_byte[7:4] == CONF_MODE) begin
                            pend_q       <= acc_byte;
                            cnt_q        <= '0;
                            mode_pending <= 1'b1;
                            state_q      <= WAIT_FRAME;
                        end else begin
                            cfg_byte <= acc_byte;
                        end
                    end
                end
                WAIT_FRAME: begin
                    if (frame_boundary || timeout_hit) begin
                        cfg_byte          <= pend_q;
                        stall_mode_change <= 1'b0;
                        mode_pending      <= 1'b0;
                        timeout_pulse     <= !frame_boundary;
                        state_q           <= IDLE;
                    end
                    if (cnt_q != CNT_MAX) begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_config_write_scheduler.sv
module tb_config_write_scheduler;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       uart_valid = 1'b0;
    logic [7:0] uart_byte = 8'h00;
    logic       uart_ready;
    logic       btn_valid = 1'b0;
    logic [7:0] btn_byte = 8'h00;
    logic       btn_ready;
    logic       frame_boundary = 1'b0;
    logic [7:0] cfg_byte;
    logic       stall_mode_change;
    logic       mode_pending;
    logic       grant_src;
    logic       timeout_pulse;

    int tests = 0;
    int fails = 0;

    config_write_scheduler #(
        .TIMEOUT  (16),
        .RST_BYTE (8'h1F)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .uart_valid        (uart_valid),
        .uart_byte         (uart_byte),
        .uart_ready        (uart_ready),
        .btn_valid         (btn_valid),
        .btn_byte          (btn_byte),
        .btn_ready         (btn_ready),
        .frame_boundary    (frame_boundary),
        .cfg_byte          (cfg_byte),
        .stall_mode_change (stall_mode_change),
        .mode_pending      (mode_pending),
        .grant_src         (grant_src),
        .timeout_pulse     (timeout_pulse)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       uv;
        logic [7:0] ub;
        logic       bv;
        logic [7:0] bb;
        logic       ur;
        logic       br;
        logic [7:0] cfg;
        logic       gsrc;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Apply inputs just after an edge, then let combinational readies settle.
    task automatic drive(input logic uv, input logic [7:0] ub, input logic bv,
                         input logic [7:0] bb, input logic fb);
        uart_valid     = uv;
        uart_byte      = ub;
        btn_valid      = bv;
        btn_byte       = bb;
        frame_boundary = fb;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_regs(input string tag, input logic [7:0] cfg, input logic stall,
                            input logic pend, input logic to);
        chk({tag, ".cfg_byte"}, {8'h00, cfg_byte}, {8'h00, cfg});
        chk({tag, ".stall"}, {15'h0, stall_mode_change}, {15'h0, stall});
        chk({tag, ".mode_pending"}, {15'h0, mode_pending}, {15'h0, pend});
        chk({tag, ".timeout_pulse"}, {15'h0, timeout_pulse}, {15'h0, to});
    endtask

    initial begin
        logic bad;

        //          uv    ub     bv    bb     ur    br    cfg    gsrc
        vecs[0] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 8'h1F, 1'b1};
        vecs[1] = '{1'b1, 8'h18, 1'b0, 8'h00, 1'b1, 1'b0, 8'h18, 1'b0};
        vecs[2] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 8'h18, 1'b0};
        vecs[3] = '{1'b0, 8'h00, 1'b1, 8'h1C, 1'b0, 1'b1, 8'h1C, 1'b1};
        vecs[4] = '{1'b1, 8'h15, 1'b1, 8'h1A, 1'b1, 1'b0, 8'h15, 1'b0};
        vecs[5] = '{1'b1, 8'h15, 1'b1, 8'h1A, 1'b0, 1'b1, 8'h1A, 1'b1};
        vecs[6] = '{1'b1, 8'h16, 1'b1, 8'h1B, 1'b1, 1'b0, 8'h16, 1'b0};
        vecs[7] = '{1'b1, 8'h2F, 1'b0, 8'h00, 1'b1, 1'b0, 8'h2F, 1'b0};
        vecs[8] = '{1'b0, 8'h00, 1'b1, 8'h1D, 1'b0, 1'b1, 8'h1D, 1'b1};
        vecs[9] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 8'h1D, 1'b1};

        // Reset, then 20 idle cycles.
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        chk("reset.grant_src", {15'h0, grant_src}, 16'h1);
        chk_regs("reset", 8'h1F, 1'b1, 1'b0, 1'b0);
        bad = 1'b0;
        for (int i = 0; i < 20; i++) begin
            drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
            if (uart_ready || btn_ready) bad = 1'b1;
            tick();
            if (cfg_byte !== 8'h1F || stall_mode_change !== 1'b1 || mode_pending !== 1'b0)
                bad = 1'b1;
        end
        chk("idle20", {15'h0, bad}, 16'h0);

        // Table-driven non-mode traffic and arbitration.
        for (int i = 0; i < 10; i++) begin
            drive(vecs[i].uv, vecs[i].ub, vecs[i].bv, vecs[i].bb, 1'b0);
            chk($sformatf("vec%0d.uart_ready", i), {15'h0, uart_ready}, {15'h0, vecs[i].ur});
            chk($sformatf("vec%0d.btn_ready", i), {15'h0, btn_ready}, {15'h0, vecs[i].br});
            tick();
            chk($sformatf("vec%0d.grant_src", i), {15'h0, grant_src}, {15'h0, vecs[i].gsrc});
            chk_regs($sformatf("vec%0d", i), vecs[i].cfg, 1'b1, 1'b0, 1'b0);
        end

        // Mode byte 02 on a tie (UART wins, button was last); same-cycle boundary ignored.
        drive(1'b1, 8'h02, 1'b1, 8'h1A, 1'b1);
        chk("mode.uart_ready", {15'h0, uart_ready}, 16'h1);
        chk("mode.btn_ready", {15'h0, btn_ready}, 16'h0);
        tick();
        chk("mode.grant_src", {15'h0, grant_src}, 16'h0);
        chk_regs("mode.accept", 8'h1D, 1'b1, 1'b1, 1'b0);
        bad = 1'b0;
        for (int i = 1; i <= 9; i++) begin
            drive(1'b1, 8'h11, 1'b1, 8'h1A, 1'b0);
            if (uart_ready || btn_ready) bad = 1'b1;
            tick();
            if (mode_pending !== 1'b1 || stall_mode_change !== 1'b1 || cfg_byte !== 8'h1D)
                bad = 1'b1;
        end
        chk("mode.wait", {15'h0, bad}, 16'h0);
        drive(1'b0, 8'h00, 1'b1, 8'h1A, 1'b1);
        chk("mode.fb_btn_ready", {15'h0, btn_ready}, 16'h0);
        tick();
        chk_regs("mode.issue", 8'h02, 1'b0, 1'b0, 1'b0);
        // Next byte accepted in the issue cycle; stall must still return high.
        drive(1'b0, 8'h00, 1'b1, 8'h1A, 1'b0);
        chk("mode.after_btn_ready", {15'h0, btn_ready}, 16'h1);
        tick();
        chk_regs("mode.after", 8'h1A, 1'b1, 1'b0, 1'b0);

        // Timeout: mode byte 03, no boundary; issue visible 17 cycles after acceptance.
        drive(1'b1, 8'h03, 1'b0, 8'h00, 1'b0);
        chk("to.uart_ready", {15'h0, uart_ready}, 16'h1);
        tick();
        bad = 1'b0;
        for (int i = 1; i <= 15; i++) begin
            drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
            tick();
            if (mode_pending !== 1'b1 || stall_mode_change !== 1'b1 || timeout_pulse !== 1'b0)
                bad = 1'b1;
        end
        chk("to.wait", {15'h0, bad}, 16'h0);
        drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
        tick();
        chk_regs("to.issue", 8'h03, 1'b0, 1'b0, 1'b1);
        tick();
        chk_regs("to.after", 8'h03, 1'b1, 1'b0, 1'b0);

        // Boundary coinciding with the timeout cycle: boundary exit, no pulse.
        drive(1'b0, 8'h00, 1'b1, 8'h04, 1'b0);
        tick();
        for (int i = 1; i <= 15; i++) begin
            drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
            tick();
        end
        chk("tofb.pending", {15'h0, mode_pending}, 16'h1);
        drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
        tick();
        chk_regs("tofb.issue", 8'h04, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);

        // Reset mid-wait discards the pending mode byte.
        drive(1'b1, 8'h05, 1'b0, 8'h00, 1'b0);
        tick();
        drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 5; i++) tick();
        chk("rstw.pending", {15'h0, mode_pending}, 16'h1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_regs("rstw.reset", 8'h1F, 1'b1, 1'b0, 1'b0);
        chk("rstw.grant_src", {15'h0, grant_src}, 16'h1);
        bad = 1'b0;
        drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
        tick();
        if (stall_mode_change !== 1'b1 || cfg_byte !== 8'h1F || mode_pending !== 1'b0)
            bad = 1'b1;
        drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 20; i++) begin
            tick();
            if (stall_mode_change !== 1'b1 || cfg_byte !== 8'h1F || mode_pending !== 1'b0)
                bad = 1'b1;
        end
        chk("rstw.no_write", {15'h0, bad}, 16'h0);
        // Pointer back to button after reset, so UART wins the first tie.
        drive(1'b1, 8'h17, 1'b1, 8'h19, 1'b0);
        chk("rstw.tie_uart", {15'h0, uart_ready}, 16'h1);
        tick();
        chk_regs("rstw.tie", 8'h17, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/config_write_scheduler.md
Name: config_write_scheduler

Overview:
- Shares the single config-byte write path into the cube's configuration register block between two requesters: the UART receiver and the front-panel button encoder.
- Non-mode commands are issued immediately.
- Mode-change commands (upper nibble 0) are deferred until the scan engine's frame boundary, so a mode switch never tears a displayed frame.
- Sits between the requesters and the config register block. It drives that block's command byte and its stall_mode_change input.

Parameters:
- TIMEOUT, 4096, cycles to wait for frame_boundary before force-issuing a pending mode command; 0 disables the timeout.
- RST_BYTE, 8'h1F, cfg_byte reset value (brightness = F, idempotent with config reset).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- uart_valid  in  1  UART command byte valid
- uart_byte  in  8  UART command byte {conf_i, conf_d}
- uart_ready  out  1  UART byte accepted this cycle when valid&ready
- btn_valid  in  1  button command byte valid
- btn_byte  in  8  button command byte
- btn_ready  out  1  button byte accepted when valid&ready
- frame_boundary  in  1  one-cycle pulse from scan engine at end of frame
- cfg_byte  out  8  command byte to config register block (registered, holds last issued)
- stall_mode_change  out  1  low only in the cycle a mode command is presented (registered)
- mode_pending  out  1  mode command waiting for frame boundary
- grant_src  out  1  source of last accepted byte, 0 = UART, 1 = button
- timeout_pulse  out  1  one-cycle pulse when a mode command is force-issued by timeout

Behaviour:
- Reset values: cfg_byte = RST_BYTE, stall_mode_change = 1, mode_pending = 0, grant_src = 1, timeout_pulse = 0, state = IDLE, counter = 0, last-grant pointer = button (UART wins first tie).
- FSM states: IDLE, WAIT_FRAME.
- IDLE, readies:
  - Readies are combinational: ready = (state == IDLE) && granted.
  - Only one source is granted per cycle. A lone valid source is granted.
  - When both sources are valid, round-robin: grant goes to the source not granted last. The pointer updates only on an accepted byte.
  - Ready is not asserted toward a source whose valid is low.
- Accepted byte with upper nibble != 0:
  - Next cycle cfg_byte = byte (latency 1); stall_mode_change stays 1.
  - grant_src updates on the same edge. State stays IDLE.
  - Back-to-back acceptance every cycle is allowed.
- Accepted byte with upper nibble == 0:
  - Latched into pend_reg; state goes to WAIT_FRAME; mode_pending = 1 next cycle.
  - Counter cleared; cfg_byte unchanged.
- WAIT_FRAME:
  - Both readies are 0 and the counter increments each cycle.
  - A frame_boundary in the same cycle as the mode acceptance is ignored; the next boundary is required.
  - Exit condition is frame_boundary, or (TIMEOUT != 0 && counter == TIMEOUT-1).
  - On exit, next cycle: cfg_byte = pend_reg, stall_mode_change = 0, mode_pending = 0, state = IDLE.
  - timeout_pulse = 1 only if the exit was by timeout without a boundary. A boundary coinciding with the timeout counts as a boundary exit: no pulse.
- The cycle after issue, stall_mode_change returns to 1 unconditionally, even if the next byte is accepted in that cycle.
- cfg_byte holds the last issued value indefinitely. The config block re-latches it every cycle, which is idempotent. A held mode byte never re-writes the mode because stall is 1.
- Counter width is $clog2(TIMEOUT+1), minimum 1. It saturates at TIMEOUT-1 and never wraps.
- rst mid-WAIT_FRAME discards pend_reg; no mode write occurs. All outputs return to reset values on the next edge.

Decomposition:
- Package cube_cfg_pkg:
  - CONF_MODE = 4'd0, CONF_BRIGHT = 4'd1
  - RST_CFG_BYTE = 8'h1F
  - typedef enum sched_state_t {IDLE, WAIT_FRAME}
  - typedef enum logic src_t {SRC_UART, SRC_BTN}
- Sub-module rr_arb2: 2-way round-robin arbiter with pointer update on accept. Keep it reusable.

Test Plan:
- Reset, then no traffic for 20 cycles -> cfg_byte = 8'h1F, stall_mode_change = 1, both readies 0, mode_pending = 0.
- uart_byte 8'h18 valid for one cycle -> uart_ready = 1 that cycle; next cycle cfg_byte = 8'h18, grant_src = 0, stall stays 1.
- uart 8'h15 and btn 8'h1A both valid for two cycles -> UART accepted first, button second; cfg_byte sequence 8'h15 then 8'h1A; grant_src 0 then 1.
- UART 8'h02 accepted, frame_boundary 10 cycles later -> mode_pending 1 for those cycles; readies 0 despite btn_valid; cycle after boundary cfg_byte = 8'h02 with stall 0 for exactly one cycle; IDLE next.
- TIMEOUT = 16, mode byte 8'h03, no frame_boundary -> cfg_byte = 8'h03 with stall 0, and timeout_pulse = 1 together, 17 cycles after acceptance.
- Mode byte accepted, rst asserted mid-wait, then frame_boundary -> no stall low cycle ever; cfg_byte = 8'h1F; mode_pending = 0.
